// File: rtl/fmap_stream_reader_if.sv
// Feature-map reader bus: synchronous buffer read port plus the tagged valid/ready output stream.
// master = reader side (fmap_stream_reader), slave = buffer/downstream side.
interface fmap_stream_reader_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned HEIGHT   = 28,
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned ADDR_W   = 11
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [BITWIDTH-1:0] mem_rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic [CH_W-1:0]     out_ch;
  logic [ROW_W-1:0]    out_row;
  logic [COL_W-1:0]    out_col;
  logic                out_eol;
  logic                out_eof;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_ch, out_row, out_col, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_ch, out_row, out_col, out_eol, out_eof,
    output out_ready
  );
endinterface

// File: rtl/fmap_stream_reader.sv
// Streams a CHANNELS x HEIGHT x WIDTH feature map out of a synchronous-read buffer with coordinate
// tags. Optional FMAP_READER_RELU_EN clamps negative words to zero and adds a sticky neg_seen flag.
module fmap_stream_reader #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned HEIGHT   = 28,
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
`ifdef FMAP_READER_RELU_EN
  output logic                 neg_seen,
`endif
  fmap_stream_reader_if.master bus
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned TAG_W = CH_W + ROW_W + COL_W + 2;
  localparam int unsigned ENT_W = BITWIDTH + TAG_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q;

  // Coordinates of the next read to issue; forced to zero while idle so a start begins at 0.
  logic [CH_W-1:0]   nxt_ch_q, cur_ch, nxt_ch_d;
  logic [ROW_W-1:0]  nxt_row_q, cur_row, nxt_row_d;
  logic [COL_W-1:0]  nxt_col_q, cur_col, nxt_col_d;
  logic [ADDR_W-1:0] nxt_addr_q, cur_addr;
  logic              col_last, row_last, ch_last, last_cell;
  logic [TAG_W-1:0]  cur_tag;

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [TAG_W-1:0]  iss_tag_q;   // tags of the read on the bus this cycle
  logic [TAG_W-1:0]  pipe_tag_q;  // tags of the data returning this cycle
  logic              inflight_q;

  logic [ENT_W-1:0]  fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;

  logic [BITWIDTH-1:0] word_in;
  logic [ENT_W-1:0]    in_ent, head_ent;
  logic                out_valid, pop, pop_fifo, push, issue;
  logic [2:0]          occ_next;

  assign cur_ch   = (state_q == StIdle) ? '0 : nxt_ch_q;
  assign cur_row  = (state_q == StIdle) ? '0 : nxt_row_q;
  assign cur_col  = (state_q == StIdle) ? '0 : nxt_col_q;
  assign cur_addr = (state_q == StIdle) ? '0 : nxt_addr_q;

  assign col_last  = (cur_col == COL_W'(WIDTH - 1));
  assign row_last  = (cur_row == ROW_W'(HEIGHT - 1));
  assign ch_last   = (cur_ch == CH_W'(CHANNELS - 1));
  assign last_cell = ch_last && row_last && col_last;
  assign cur_tag   = {cur_ch, cur_row, cur_col, col_last, last_cell};

  always_comb begin
    nxt_col_d = cur_col + COL_W'(1);
    nxt_row_d = cur_row;
    nxt_ch_d  = cur_ch;
    if (col_last) begin
      nxt_col_d = '0;
      nxt_row_d = cur_row + ROW_W'(1);
      if (row_last) begin
        nxt_row_d = '0;
        nxt_ch_d  = ch_last ? '0 : cur_ch + CH_W'(1);
      end
    end
  end

`ifdef FMAP_READER_RELU_EN
  assign word_in = bus.mem_rd_data[BITWIDTH-1] ? '0 : bus.mem_rd_data;
`else
  assign word_in = bus.mem_rd_data;
`endif

  // Two-entry fall-through skid: returning data bypasses straight to the output when empty.
  assign in_ent    = {word_in, pipe_tag_q};
  assign out_valid = (count_q != 2'd0) || inflight_q;
  assign head_ent  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : in_ent;
  assign pop       = out_valid && bus.out_ready;
  assign pop_fifo  = pop && (count_q != 2'd0);
  assign push      = inflight_q && !(pop && (count_q == 2'd0));
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop_fifo};

  // Next-cycle buffered + in-flight words; a new read is only issued while that stays below 2.
  assign occ_next = {1'b0, count_d} + {2'b00, rd_en_q};
  assign issue    = (state_q == StIdle) ? start : ((state_q == StRun) && (occ_next < 3'd2));

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.out_valid   = out_valid;
  assign {bus.out_data, bus.out_ch, bus.out_row, bus.out_col, bus.out_eol, bus.out_eof} =
      out_valid ? head_ent : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          if (issue && last_cell) state_q <= StDrain;
        end
        StDrain: begin
          if (pop && head_ent[0]) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      nxt_ch_q   <= '0;
      nxt_row_q  <= '0;
      nxt_col_q  <= '0;
      nxt_addr_q <= '0;
      iss_tag_q  <= '0;
      pipe_tag_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_en_q    <= issue;
      inflight_q <= rd_en_q;
      pipe_tag_q <= iss_tag_q;
      if (issue) begin
        rd_addr_q  <= cur_addr;
        iss_tag_q  <= cur_tag;
        nxt_ch_q   <= nxt_ch_d;
        nxt_row_q  <= nxt_row_d;
        nxt_col_q  <= nxt_col_d;
        nxt_addr_q <= cur_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= in_ent;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

`ifdef FMAP_READER_RELU_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_seen <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      neg_seen <= 1'b0;
    end else if (inflight_q && bus.mem_rd_data[BITWIDTH-1]) begin
      neg_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: clean frame, backpressure, negative word, channel wrap,
// mid-frame reset and start-while-busy.
module tb_fmap_stream_reader;
  localparam int N = 1568;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic busy, done;
`ifdef FMAP_READER_RELU_EN
  logic neg_seen;
`endif

  fmap_stream_reader_if bus ();

  fmap_stream_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef FMAP_READER_RELU_EN
    .neg_seen (neg_seen),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [N];
  logic [31:0] rd_data_q = '0;
  always @(posedge clk) if (bus.mem_rd_en) rd_data_q <= mem[int'(bus.mem_rd_addr)];
  assign bus.mem_rd_data = rd_data_q;
  assign bus.out_ready   = ready;

  int tests = 0;
  int fails = 0;

  logic [31:0] g_data [N];
  logic        g_ch   [N];
  logic [4:0]  g_row  [N];
  logic [4:0]  g_col  [N];
  logic        g_eol  [N];
  logic        g_eof  [N];
  int n_got, done_cnt, done_cyc, last_hs, first_valid, stall_err, occ_err, addr_err;
  bit saw784;

  task automatic set_mem_clean();
    for (int k = 0; k < N; k++) mem[k] = '0;
    mem[0]  = 32'd1;
    mem[1]  = 32'd2;
    mem[28] = 32'd3;
  endtask

  function automatic int seq_errors();
    int bad = 0;
    logic [31:0] w;
    for (int k = 0; k < N; k++) begin
      w = mem[k];
`ifdef FMAP_READER_RELU_EN
      if (w[31]) w = '0;
`endif
      if (g_data[k] !== w || g_ch[k] !== 1'(k / 784) || g_row[k] !== 5'((k % 784) / 28) ||
          g_col[k] !== 5'(k % 28) || g_eol[k] !== (k % 28 == 27) || g_eof[k] !== (k == N - 1))
        bad++;
    end
    return bad;
  endfunction

  // Runs one frame from start; called and returns just after a rising edge.
  task automatic stream_frame(input int mode, input int inj_at, input int stop_at);
    int issued = 0;
    int hs = 0;
    bit injected = 0;
    bit held = 0;
    logic [31:0] p_data;
    logic p_ch, p_eol, p_eof;
    logic [4:0] p_row, p_col;
    n_got = 0; done_cnt = 0; done_cyc = -1; last_hs = -1; first_valid = -1;
    stall_err = 0; occ_err = 0; addr_err = 0; saw784 = 0;
    for (int k = 0; k < N; k++) g_data[k] = 'x;
    for (int c = 0; c < 8000; c++) begin
      start = (c == 0);
      if (inj_at >= 0 && !injected && n_got >= inj_at) begin
        start = 1'b1;
        injected = 1;
      end
      ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      @(negedge clk);
      if (bus.out_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (held && (!bus.out_valid || bus.out_data !== p_data || bus.out_ch !== p_ch ||
                   bus.out_row !== p_row || bus.out_col !== p_col || bus.out_eol !== p_eol ||
                   bus.out_eof !== p_eof))
        stall_err++;
      if (bus.mem_rd_en) begin
        if (issued - hs >= 2) occ_err++;
        if (int'(bus.mem_rd_addr) != issued) addr_err++;
        if (int'(bus.mem_rd_addr) == 784) saw784 = 1;
        issued++;
      end
      held = bus.out_valid && !ready;
      p_data = bus.out_data; p_ch = bus.out_ch; p_row = bus.out_row; p_col = bus.out_col;
      p_eol = bus.out_eol; p_eof = bus.out_eof;
      if (bus.out_valid && ready) begin
        if (n_got < N) begin
          g_data[n_got] = bus.out_data; g_ch[n_got] = bus.out_ch; g_row[n_got] = bus.out_row;
          g_col[n_got] = bus.out_col; g_eol[n_got] = bus.out_eol; g_eof[n_got] = bus.out_eof;
        end
        n_got++;
        hs++;
        last_hs = c;
      end
      if (stop_at >= 0 && n_got >= stop_at) break;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, done, bus.mem_rd_en, bus.mem_rd_addr} !== 14'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %h want 0", {busy, done, bus.mem_rd_en, bus.mem_rd_addr});
    end
    tests++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.out_row, bus.out_col, bus.out_eol,
         bus.out_eof} !== 46'd0) begin
      fails++;
      $display("FAIL reset_stream: got %h want 0", {bus.out_valid, bus.out_data, bus.out_ch,
               bus.out_row, bus.out_col, bus.out_eol, bus.out_eof});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_frame();
    int bad;
    set_mem_clean();
    stream_frame(0, -1, -1);
    tests++;
    if (n_got != N) begin fails++; $display("FAIL clean_count: got %0d want %0d", n_got, N); end
    tests++;
    if ({g_data[0], g_ch[0], g_row[0], g_col[0]} !== {32'd1, 1'b0, 5'd0, 5'd0}) begin
      fails++; $display("FAIL clean_word0: got %h/%0d/%0d/%0d want 1/0/0/0",
                        g_data[0], g_ch[0], g_row[0], g_col[0]);
    end
    tests++;
    if ({g_data[1], g_ch[1], g_row[1], g_col[1]} !== {32'd2, 1'b0, 5'd0, 5'd1}) begin
      fails++; $display("FAIL clean_word1: got %h/%0d/%0d/%0d want 2/0/0/1",
                        g_data[1], g_ch[1], g_row[1], g_col[1]);
    end
    tests++;
    if ({g_data[28], g_ch[28], g_row[28], g_col[28]} !== {32'd3, 1'b0, 5'd1, 5'd0}) begin
      fails++; $display("FAIL clean_word28: got %h/%0d/%0d/%0d want 3/0/1/0",
                        g_data[28], g_ch[28], g_row[28], g_col[28]);
    end
    bad = seq_errors();
    tests++;
    if (bad != 0) begin fails++; $display("FAIL clean_sequence: %0d bad words want 0", bad); end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL clean_done_count: got %0d want 1", done_cnt); end
    tests++;
    if (done_cyc != last_hs + 1) begin
      fails++; $display("FAIL clean_done_timing: got cycle %0d want %0d", done_cyc, last_hs + 1);
    end
    tests++;
    if (first_valid != 2) begin
      fails++; $display("FAIL clean_latency: got %0d want 2", first_valid);
    end
    tests++;
    if (addr_err != 0 || occ_err != 0) begin
      fails++; $display("FAIL clean_issue: addr_err %0d occ_err %0d want 0/0", addr_err, occ_err);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL clean_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_channel_wrap();
    set_mem_clean();
    stream_frame(0, -1, -1);
    tests++;
    if ({g_ch[783], g_row[783], g_col[783], g_eol[783], g_eof[783]} !==
        {1'b0, 5'd27, 5'd27, 1'b1, 1'b0}) begin
      fails++; $display("FAIL wrap_word783: got %0d/%0d/%0d eol %b eof %b want 0/27/27 1 0",
                        g_ch[783], g_row[783], g_col[783], g_eol[783], g_eof[783]);
    end
    tests++;
    if ({g_ch[784], g_row[784], g_col[784], g_eol[784], g_eof[784]} !==
        {1'b1, 5'd0, 5'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL wrap_word784: got %0d/%0d/%0d eol %b eof %b want 1/0/0 0 0",
                        g_ch[784], g_row[784], g_col[784], g_eol[784], g_eof[784]);
    end
    tests++;
    if (saw784 != 1 || addr_err != 0) begin
      fails++; $display("FAIL wrap_addr784: seen %0d addr_err %0d want 1/0", saw784, addr_err);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    set_mem_clean();
    stream_frame(1, -1, -1);
    bad = seq_errors();
    tests++;
    if (n_got != N) begin fails++; $display("FAIL bp_count: got %0d want %0d", n_got, N); end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL bp_sequence: %0d bad words want 0", bad); end
    tests++;
    if (stall_err != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable want 0", stall_err); end
    tests++;
    if (occ_err != 0) begin fails++; $display("FAIL bp_occupancy: got %0d overfills want 0", occ_err); end
    tests++;
    if (addr_err != 0) begin fails++; $display("FAIL bp_addr: got %0d bad addrs want 0", addr_err); end
    tests++;
    if (done_cnt != 1 || done_cyc != last_hs + 1) begin
      fails++; $display("FAIL bp_done: count %0d cycle %0d want 1 at %0d", done_cnt, done_cyc,
                        last_hs + 1);
    end
  endtask

  task automatic test_negative();
    logic [31:0] exp29;
    set_mem_clean();
    mem[29] = 32'hFFFF_FB87;
`ifdef FMAP_READER_RELU_EN
    exp29 = 32'h0;
`else
    exp29 = 32'hFFFF_FB87;
`endif
    stream_frame(0, -1, -1);
    tests++;
    if (g_data[29] !== exp29) begin
      fails++; $display("FAIL neg_word29: got %h want %h", g_data[29], exp29);
    end
    tests++;
    if (n_got != N) begin fails++; $display("FAIL neg_count: got %0d want %0d", n_got, N); end
`ifdef FMAP_READER_RELU_EN
    tests++;
    if (neg_seen !== 1'b1) begin fails++; $display("FAIL neg_seen_set: got %b want 1", neg_seen); end
    mem[29] = 32'h0;
    stream_frame(0, -1, -1);
    tests++;
    if (neg_seen !== 1'b0) begin fails++; $display("FAIL neg_seen_clear: got %b want 0", neg_seen); end
`endif
  endtask

  task automatic test_reset_mid();
    int aborted_done;
    int late_done = 0;
    int bad;
    set_mem_clean();
    stream_frame(0, -1, 400);
    aborted_done = done_cnt;
    tests++;
    if (n_got != 400) begin fails++; $display("FAIL rmid_reach: got %0d want 400", n_got); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, bus.mem_rd_en, bus.mem_rd_addr} !== 14'd0) begin
      fails++; $display("FAIL rmid_ctrl: got %h want 0", {busy, done, bus.mem_rd_en, bus.mem_rd_addr});
    end
    tests++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.out_row, bus.out_col, bus.out_eol,
         bus.out_eof} !== 46'd0) begin
      fails++; $display("FAIL rmid_stream: got %h want 0", {bus.out_valid, bus.out_data,
               bus.out_ch, bus.out_row, bus.out_col, bus.out_eol, bus.out_eof});
    end
    repeat (3) begin
      @(negedge clk);
      if (done) late_done++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) late_done++;
    end
    @(posedge clk); #1;
    tests++;
    if (aborted_done + late_done != 0) begin
      fails++; $display("FAIL rmid_no_done: got %0d pulses want 0", aborted_done + late_done);
    end
    mem[0] = 32'h0000_00A5;
    stream_frame(0, -1, -1);
    bad = seq_errors();
    tests++;
    if (g_data[0] !== 32'h0000_00A5) begin
      fails++; $display("FAIL rmid_restart_word0: got %h want 000000a5", g_data[0]);
    end
    tests++;
    if (n_got != N || bad != 0) begin
      fails++; $display("FAIL rmid_restart_frame: count %0d bad %0d want %0d/0", n_got, bad, N);
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL rmid_restart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_while_busy();
    int bad;
    set_mem_clean();
    stream_frame(0, 10, -1);
    bad = seq_errors();
    tests++;
    if (n_got != N) begin fails++; $display("FAIL sbusy_count: got %0d want %0d", n_got, N); end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL sbusy_done: got %0d want 1", done_cnt); end
    tests++;
    if (bad != 0 || addr_err != 0) begin
      fails++; $display("FAIL sbusy_sequence: bad %0d addr_err %0d want 0/0", bad, addr_err);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_channel_wrap();
    test_backpressure();
    test_negative();
    test_reset_mid();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
